// File: rtl/norflash16_wb_pkg.sv
// Shared definitions for the 16-bit NOR flash Wishbone bridge.
package norflash16_wb_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_HI    = 3'd1,
    S_RD_LO    = 3'd2,
    S_WR_SETUP = 3'd3,
    S_WR_PULSE = 3'd4,
    S_WR_HOLD  = 3'd5,
    S_ACK      = 3'd6
  } state_e;

  // Low two flash byte-address bits selecting the halfword of a 32-bit word
  localparam logic [1:0] FLASH_HALF_HI = 2'b00;
  localparam logic [1:0] FLASH_HALF_LO = 2'b10;

endpackage

// File: rtl/norflash16_wb.sv
// Wishbone slave to 16-bit parallel NOR flash: 32-bit reads as two timed
// big-endian halfword reads, halfword writes as timed write pulses.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for a new cycle; flash deselected
// S_RD_HI    | reading halfword at offset 0 (-> wb_dat_o[31:16])
// S_RD_LO    | reading halfword at offset 2 (-> wb_dat_o[15:0])
// S_WR_SETUP | address/data setup before the write pulse
// S_WR_PULSE | flash_we_n held low for WR_TIMING cycles
// S_WR_HOLD  | address/data hold; maybe start the second halfword
// S_ACK      | wb_ack_o high for this single cycle
module norflash16_wb
  import norflash16_wb_pkg::*;
#(
  parameter int ADR_WIDTH = 24,
  parameter int RD_TIMING = 6,
  parameter int WR_TIMING = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_we_i,
  output logic                 wb_ack_o,
  output logic [ADR_WIDTH-1:0] flash_adr,
  input  logic [15:0]          flash_d_i,
  output logic [15:0]          flash_d_o,
  output logic                 flash_d_oe,
  output logic                 flash_ce_n,
  output logic                 flash_oe_n,
  output logic                 flash_we_n
);

  localparam int MAX_T = (RD_TIMING > WR_TIMING) ? RD_TIMING : WR_TIMING;
  localparam int CW    = $clog2(MAX_T + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_TIMING - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_TIMING - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [15:0]            dout_q, dout_d;
  logic [31:0]            dat_q, dat_d;
  logic                   doe_q, doe_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic                   ack_q, ack_d;
  logic                   wr_hi_q, wr_hi_d;

  logic                   cnt_zero;
  logic [ADR_WIDTH-3:0]   req_word;
  logic                   unused_adr;

  assign cnt_zero   = (cnt_q == '0);
  assign req_word   = wb_adr_i[ADR_WIDTH-1:2];
  assign unused_adr = ^{wb_adr_i[31:ADR_WIDTH], wb_adr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dout_d  = dout_q;
    dat_d   = dat_q;
    doe_d   = doe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    ack_d   = 1'b0;
    wr_hi_d = wr_hi_q;

    unique case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i && !ack_q) begin
          if (!wb_we_i) begin
            adr_d   = {req_word, FLASH_HALF_HI};
            ce_n_d  = 1'b0;
            oe_n_d  = 1'b0;
            cnt_d   = RD_LOAD;
            state_d = S_RD_HI;
          end else if (|wb_sel_i[3:2]) begin
            adr_d   = {req_word, FLASH_HALF_HI};
            dout_d  = wb_dat_i[31:16];
            doe_d   = 1'b1;
            ce_n_d  = 1'b0;
            wr_hi_d = 1'b1;
            state_d = S_WR_SETUP;
          end else if (|wb_sel_i[1:0]) begin
            adr_d   = {req_word, FLASH_HALF_LO};
            dout_d  = wb_dat_i[15:0];
            doe_d   = 1'b1;
            ce_n_d  = 1'b0;
            wr_hi_d = 1'b0;
            state_d = S_WR_SETUP;
          end else begin
            ack_d   = 1'b1;
            state_d = S_ACK;
          end
        end
      end

      S_RD_HI: begin
        if (!wb_cyc_i) begin
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_zero) begin
          dat_d[31:16] = flash_d_i;
          adr_d   = {adr_q[ADR_WIDTH-1:2], FLASH_HALF_LO};
          cnt_d   = RD_LOAD;
          state_d = S_RD_LO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RD_LO: begin
        if (!wb_cyc_i) begin
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_zero) begin
          dat_d[15:0] = flash_d_i;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // An abandoned cycle is dropped here, before any pulse has begun
      S_WR_SETUP: begin
        if (!wb_cyc_i) begin
          doe_d   = 1'b0;
          ce_n_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          we_n_d  = 1'b0;
          cnt_d   = WR_LOAD;
          state_d = S_WR_PULSE;
        end
      end

      // The pulse always runs to completion so the flash never sees a short write
      S_WR_PULSE: begin
        if (cnt_zero) begin
          we_n_d  = 1'b1;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WR_HOLD: begin
        if (!wb_cyc_i) begin
          doe_d   = 1'b0;
          ce_n_d  = 1'b1;
          state_d = S_IDLE;
        end else if (wr_hi_q && (|wb_sel_i[1:0])) begin
          adr_d   = {adr_q[ADR_WIDTH-1:2], FLASH_HALF_LO};
          dout_d  = wb_dat_i[15:0];
          wr_hi_d = 1'b0;
          state_d = S_WR_SETUP;
        end else begin
          doe_d   = 1'b0;
          ce_n_d  = 1'b1;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        doe_d   = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dout_q  <= '0;
      dat_q   <= '0;
      doe_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      wr_hi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
      dat_q   <= dat_d;
      doe_q   <= doe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ack_q   <= ack_d;
      wr_hi_q <= wr_hi_d;
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign flash_adr  = adr_q;
  assign flash_d_o  = dout_q;
  assign flash_d_oe = doe_q;
  assign flash_ce_n = ce_n_q;
  assign flash_oe_n = oe_n_q;
  assign flash_we_n = we_n_q;

endmodule

// File: tb/tb_norflash16_wb.sv
// Directed bench for norflash16_wb: vector table plus hand-written corner sequences.
module tb_norflash16_wb;

  localparam int AW  = 24;
  localparam int RDT = 6;
  localparam int WRT = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [31:0]   wb_adr_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_i = '0;
  logic          wb_stb_i = 1'b0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic          wb_ack_o;
  logic [AW-1:0] flash_adr;
  logic [15:0]   flash_d_i;
  logic [15:0]   flash_d_o;
  logic          flash_d_oe;
  logic          flash_ce_n;
  logic          flash_oe_n;
  logic          flash_we_n;

  int errors = 0;
  int checks = 0;

  norflash16_wb #(.ADR_WIDTH(AW), .RD_TIMING(RDT), .WR_TIMING(WRT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .flash_adr(flash_adr), .flash_d_i(flash_d_i), .flash_d_o(flash_d_o),
    .flash_d_oe(flash_d_oe), .flash_ce_n(flash_ce_n),
    .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n)
  );

  always #5 sys_clk = ~sys_clk;

  // Flash read model: two fixed words, everything else a pattern of the address
  function automatic logic [15:0] flash_rd(input logic [AW-1:0] a);
    if (a == 24'h000010) return 16'h1234;
    if (a == 24'h000012) return 16'hABCD;
    return a[15:0] ^ 16'hC3C3;
  endfunction

  assign flash_d_i = (!flash_ce_n && !flash_oe_n) ? flash_rd(flash_adr) : 16'h0000;

  // Write-pulse log, ack counter and pin-protocol watchdog
  logic [AW-1:0] wr_adr [8];
  logic [15:0]   wr_dat [8];
  int            wr_len [8];
  int            wr_n = 0;
  int            ack_cnt = 0;
  int            viol = 0;
  logic          prev_we = 1'b1;

  always @(negedge sys_clk) begin
    if (!flash_we_n && wr_n < 8) begin
      if (prev_we) begin
        wr_adr[wr_n] = flash_adr;
        wr_dat[wr_n] = flash_d_o;
        wr_len[wr_n] = 0;
        wr_n = wr_n + 1;
      end
      wr_len[wr_n-1] = wr_len[wr_n-1] + 1;
    end
    prev_we = flash_we_n;
    if (wb_ack_o) ack_cnt = ack_cnt + 1;
    if ((!flash_oe_n && !flash_we_n) || (flash_d_oe && !flash_oe_n)) viol = viol + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One Wishbone transaction; lat = rising edges after the accepting edge until ack
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output int lat, output logic [31:0] rdata,
                         output logic ack_after);
    wr_n = 0;
    @(negedge sys_clk);
    wb_we_i = we; wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge sys_clk); #1;
    lat = 0;
    while (!wb_ack_o && lat < 100) begin
      @(posedge sys_clk); #1;
      lat = lat + 1;
    end
    rdata = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge sys_clk); #1;
    ack_after = wb_ack_o;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          lat;
    logic [31:0] rdata;
    int          pulses;
    logic [23:0] a0;
    logic [15:0] d0;
    logic [23:0] a1;
    logic [15:0] d1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          lat;
    int          n;
    int          bad;
    int          acks0;
    logic [31:0] rdata;
    logic        ack_after;

    vecs[0] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         12, 32'h1234_ABCD, 0, 24'h0,   16'h0,    24'h0,   16'h0};
    vecs[1] = '{1'b1, 32'h0000_0554, 4'hC, 32'h00AA_0000, 10, 32'h0,         1, 24'h554, 16'h00AA, 24'h0,   16'h0};
    vecs[2] = '{1'b1, 32'h0000_0100, 4'hF, 32'h1111_2222, 20, 32'h0,         2, 24'h100, 16'h1111, 24'h102, 16'h2222};
    vecs[3] = '{1'b1, 32'h0000_02A8, 4'h3, 32'h0000_0055, 10, 32'h0,         1, 24'h2AA, 16'h0055, 24'h0,   16'h0};
    vecs[4] = '{1'b1, 32'h0000_0400, 4'h0, 32'hDEAD_BEEF, 0,  32'h0,         0, 24'h0,   16'h0,    24'h0,   16'h0};
    vecs[5] = '{1'b0, 32'hFF00_00FC, 4'hF, 32'h0,         12, 32'hC33F_C33D, 0, 24'h0,   16'h0,    24'h0,   16'h0};

    // Reset values
    #12;
    chk("rst_ce_n", flash_ce_n, 1);
    chk("rst_oe_n", flash_oe_n, 1);
    chk("rst_we_n", flash_we_n, 1);
    chk("rst_d_oe", flash_d_oe, 0);
    chk("rst_adr", flash_adr, 0);
    chk("rst_d_o", flash_d_o, 0);
    chk("rst_dat_o", wb_dat_o, 0);
    chk("rst_ack", wb_ack_o, 0);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, lat, rdata, ack_after);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_ack_width", i), ack_after, 0);
      if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
      chk($sformatf("v%0d_pulses", i), wr_n, vecs[i].pulses);
      if (vecs[i].pulses >= 1 && wr_n >= 1) begin
        chk($sformatf("v%0d_wr0_adr", i), wr_adr[0], vecs[i].a0);
        chk($sformatf("v%0d_wr0_dat", i), wr_dat[0], vecs[i].d0);
        chk($sformatf("v%0d_wr0_len", i), wr_len[0], WRT);
      end
      if (vecs[i].pulses >= 2 && wr_n >= 2) begin
        chk($sformatf("v%0d_wr1_adr", i), wr_adr[1], vecs[i].a1);
        chk($sformatf("v%0d_wr1_dat", i), wr_dat[1], vecs[i].d1);
        chk($sformatf("v%0d_wr1_len", i), wr_len[1], WRT);
      end
      chk($sformatf("v%0d_idle_ce_n", i), flash_ce_n, 1);
    end

    // Back-to-back reads with strobe held, including address phase timing
    @(negedge sys_clk);
    wb_we_i = 1'b0; wb_adr_i = 32'h10; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge sys_clk); #1;
      if (flash_adr !== ((k < RDT) ? 24'h10 : 24'h12) || flash_oe_n !== 1'b0 || wb_ack_o !== 1'b0)
        bad = bad + 1;
    end
    chk("b2b_rd_adr_seq", bad, 0);
    @(posedge sys_clk); #1;
    chk("b2b_ack1", wb_ack_o, 1);
    chk("b2b_rdata1", wb_dat_o, 32'h1234_ABCD);
    wb_adr_i = 32'h100;
    @(posedge sys_clk); #1;
    chk("b2b_dead_ack", wb_ack_o, 0);
    chk("b2b_dead_adr", flash_adr, 24'h12);
    @(posedge sys_clk); #1;
    chk("b2b_adr2", flash_adr, 24'h100);
    chk("b2b_oe2", flash_oe_n, 0);
    n = 0;
    while (!wb_ack_o && n < 40) begin
      @(posedge sys_clk); #1;
      n = n + 1;
    end
    chk("b2b_lat2", n, 2 * RDT);
    chk("b2b_rdata2", wb_dat_o, 32'hC2C3_C2C1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge sys_clk); #1;

    // Asynchronous reset in the middle of a write pulse
    @(negedge sys_clk);
    wb_we_i = 1'b1; wb_adr_i = 32'h554; wb_sel_i = 4'hC; wb_dat_i = 32'h00AA_0000;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (5) @(posedge sys_clk);
    #3;
    chk("arst_pre_we_low", flash_we_n, 0);
    sys_rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    #1;
    chk("arst_we_n", flash_we_n, 1);
    chk("arst_ce_n", flash_ce_n, 1);
    chk("arst_oe_n", flash_oe_n, 1);
    chk("arst_d_oe", flash_d_oe, 0);
    acks0 = ack_cnt;
    @(negedge sys_clk); sys_rst_n = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1;
    chk("arst_no_ack", ack_cnt, acks0);

    // Cycle dropped in RD_HI: nothing captured yet (wb_dat_o still reset value)
    @(negedge sys_clk);
    wb_we_i = 1'b0; wb_adr_i = 32'h10; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    acks0 = ack_cnt;
    @(posedge sys_clk); #1;
    chk("drop_hi_oe_n", flash_oe_n, 1);
    chk("drop_hi_ce_n", flash_ce_n, 1);
    repeat (15) @(posedge sys_clk);
    #1;
    chk("drop_hi_no_ack", ack_cnt, acks0);
    chk("drop_hi_dat", wb_dat_o, 32'h0);

    // Cycle dropped in RD_LO: high half kept
    @(negedge sys_clk);
    wb_adr_i = 32'h10; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (9) @(posedge sys_clk);
    @(negedge sys_clk); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge sys_clk); #1;
    chk("drop_lo_oe_n", flash_oe_n, 1);
    repeat (10) @(posedge sys_clk);
    #1;
    chk("drop_lo_no_ack", ack_cnt, acks0);
    chk("drop_lo_dat", wb_dat_o, 32'h1234_0000);

    run_txn(1'b0, 32'h10, 4'hF, 32'h0, lat, rdata, ack_after);
    chk("after_drop_lat", lat, 2 * RDT);
    chk("after_drop_rdata", rdata, 32'h1234_ABCD);

    // Cycle dropped during the first pulse of a two-halfword write
    wr_n = 0;
    acks0 = ack_cnt;
    @(negedge sys_clk);
    wb_we_i = 1'b1; wb_adr_i = 32'h200; wb_sel_i = 4'hF; wb_dat_i = 32'h5555_6666;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk); wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    repeat (25) @(posedge sys_clk);
    #1;
    chk("wdrop_pulses", wr_n, 1);
    chk("wdrop_len", wr_len[0], WRT);
    chk("wdrop_dat", wr_dat[0], 16'h5555);
    chk("wdrop_no_ack", ack_cnt, acks0);
    chk("wdrop_d_oe", flash_d_oe, 0);
    chk("wdrop_ce_n", flash_ce_n, 1);

    chk("pin_protocol", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/norflash16_wb.md
Name: norflash16_wb

Overview:
- Wishbone slave bridging the 32-bit system bus to the board's 16-bit parallel NOR flash (BIOS boot device).
- Sits directly upstream of the flash pins; the CPU fetches BIOS code through it.
- Each 32-bit read becomes two timed 16-bit flash reads, big-endian: halfword at byte offset 0 supplies bits [31:16], offset 2 supplies bits [15:0].
- Halfword writes issue timed write pulses for flash command sequences.
- Tristate is resolved at the top level.

Parameters:
- ADR_WIDTH, 24: flash byte-address width; flash_adr[0] is always 0.
- RD_TIMING, 6: sys_clk cycles per halfword read phase; must be ≥1.
- WR_TIMING, 8: sys_clk cycles flash_we_n is held low per halfword write; must be ≥1.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- wb_adr_i  in  32  byte address; bits [ADR_WIDTH-1:2] are used.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte selects.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_we_i  in  1  write enable.
- wb_ack_o  out  1  acknowledge.
- flash_adr  out  ADR_WIDTH  flash byte address.
- flash_d_i  in  16  data from the flash.
- flash_d_o  out  16  data to the flash.
- flash_d_oe  out  1  drive enable for flash_d.
- flash_ce_n  out  1  chip enable, active low.
- flash_oe_n  out  1  output enable, active low.
- flash_we_n  out  1  write enable, active low.

Behaviour:
- Reset (async, sys_rst_n=0): state IDLE; flash_ce_n, flash_oe_n and flash_we_n = 1; flash_d_oe = 0; flash_adr = 0; flash_d_o = 0; wb_dat_o = 0; wb_ack_o = 0; counter = 0.
- All outputs are registered. The phase counter is a down-counter, $clog2(max(RD_TIMING,WR_TIMING)+1) bits wide.
- States: IDLE, RD_HI, RD_LO, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE:
  - Accepts a request when wb_cyc_i & wb_stb_i & !wb_ack_o.
  - Read (wb_we_i=0): flash_adr = {wb_adr_i[ADR_WIDTH-1:2], 2'b00}; ce_n = 0; oe_n = 0; counter = RD_TIMING-1; next state RD_HI.
  - Write with wb_sel_i[3:2] != 0: halfword 0, data wb_dat_i[31:16].
  - Write with only wb_sel_i[1:0] != 0: halfword 1, data wb_dat_i[15:0].
  - Write with wb_sel_i = 0: go straight to ACK with no flash access.
  - Write, any case with a flash access: latch flash_adr and flash_d_o; d_oe = 1; ce_n = 0; next state WR_SETUP.
- RD_HI: decrement the counter. At counter 0: wb_dat_o[31:16] ← flash_d_i; flash_adr[1] = 1; counter = RD_TIMING-1; next state RD_LO.
- RD_LO: at counter 0: wb_dat_o[15:0] ← flash_d_i; ce_n = 1; oe_n = 1; wb_ack_o = 1; next state ACK.
- Read latency: wb_ack_o rises exactly 2*RD_TIMING cycles after the accepting edge.
- WR_SETUP: one cycle of address/data setup. Then we_n = 0; counter = WR_TIMING-1; next state WR_PULSE.
- WR_PULSE: at counter 0: we_n = 1; next state WR_HOLD.
- WR_HOLD: one cycle of hold.
  - If the high half was just written and wb_sel_i[1:0] != 0: flash_adr[1] = 1; flash_d_o = wb_dat_i[15:0]; next state WR_SETUP.
  - Otherwise: d_oe = 0; ce_n = 1; wb_ack_o = 1; next state ACK.
- Write latency: one halfword acks WR_TIMING+2 cycles after accept; two halfwords ack 2*WR_TIMING+4 cycles after accept.
- ACK: wb_ack_o = 0; next state IDLE. wb_ack_o is high for exactly one cycle, with at least one dead cycle before the next accept.
- wb_cyc_i drops during RD_HI or RD_LO: next edge goes to IDLE with ce_n = oe_n = 1, no ack, and wb_dat_o keeps any half already captured.
- wb_cyc_i drops during a write: the current WR_PULSE/WR_HOLD completes (no truncated pulse), then IDLE with d_oe = 0 and no ack; the second half is not started.
- flash_oe_n and flash_we_n are never low together. flash_d_oe is never 1 while oe_n = 0.

Decomposition:
- Shared package holds the state enumeration (3-bit encoding) and the FLASH_HALF_HI/LO offset constants.
- No sub-module; the single FSM plus counter is natural.

Test Plan:
- Read 0x00000010, flash model returns 0x1234 at byte 0x10 and 0xABCD at 0x12, RD_TIMING=6 → flash_adr 0x10 for 6 cycles, then 0x12 for 6 cycles; wb_dat_o = 0x1234ABCD; ack 12 cycles after accept, one cycle wide.
- Write 0x00000554, sel = 4'b1100, dat = 0x00AA0000 → flash_adr 0x554, d_o = 0x00AA, one setup cycle, we_n low 8 cycles, one hold cycle; ack 10 cycles after accept.
- Write sel = 4'b1111, dat = 0x11112222 → two pulses (0x1111 at offset 0, then 0x2222 at offset 2); ack 20 cycles after accept.
- Back-to-back reads with stb held → a dead ACK cycle separates the two acks; the second flash_adr appears on the cycle after ACK.
- Assert sys_rst_n = 0 mid-WR_PULSE → we_n, ce_n and oe_n go to 1 and d_oe to 0 immediately (asynchronously); no ack after release.
- Drop wb_cyc_i in RD_HI → IDLE next cycle, oe_n = 1, no ack; a following read completes normally.
